// File: rtl/game_pkg.sv
// Shared game constants: grid geometry, action encodings, game states and object codes.
package game_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned GRID_ROWS = 8;
    localparam int unsigned GRID_COLS = 13;
    localparam int unsigned ROW_W     = 3;
    localparam int unsigned COL_W     = 4;
    localparam int unsigned OBJ_W     = 4;

    typedef enum logic [1:0] {
        KIND_WRITE  = 2'd0,
        KIND_LOCK   = 2'd1,
        KIND_UNLOCK = 2'd2,
        KIND_RSVD   = 2'd3
    } req_kind_e;

    typedef enum logic [2:0] {
        GS_TITLE = 3'd0,
        GS_READY = 3'd1,
        GS_PLAY  = 3'd2,
        GS_PAUSE = 3'd3,
        GS_OVER  = 3'd4
    } game_state_e;

    localparam logic [2:0] PLAY_STATE = GS_PLAY;

    localparam logic [OBJ_W-1:0] G_EMPTY         = 4'd0;
    localparam logic [OBJ_W-1:0] G_COUNTER       = 4'd1;
    localparam logic [OBJ_W-1:0] G_ONION_WHOLE   = 4'd2;
    localparam logic [OBJ_W-1:0] G_ONION_CHOPPED = 4'd3;
    localparam logic [OBJ_W-1:0] G_PLATE         = 4'd4;
    localparam logic [OBJ_W-1:0] G_SOUP          = 4'd5;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } lock_entry_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational four-way round-robin picker: first set request at or after the pointer.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] sel_o,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = ptr_i;
        valid_o = 1'b0;
        // Scan from the farthest offset down so the nearest candidate wins.
        for (int off = 3; off >= 0; off--) begin
            if (req_i[ptr_i + 2'(off)]) begin
                idx_o   = ptr_i + 2'(off);
                valid_o = 1'b1;
            end
        end
        sel_o = valid_o ? (4'b0001 << idx_o) : 4'b0000;
    end

endmodule

// File: rtl/grid_action_arbiter.sv
// Serialises player actions onto the single object_grid write port, one per frame,
// and keeps per-slot cell locks so two players never work the same counter cell.
module grid_action_arbiter
    import game_pkg::*;
(
    input  logic                              vsync_i,
    input  logic                              reset_ni,
    input  logic [1:0]                        num_players_i,
    input  logic [2:0]                        game_state_i,
    input  logic [NUM_SLOTS-1:0]              req_i,
    input  logic [NUM_SLOTS-1:0][1:0]         req_kind_i,
    input  logic [NUM_SLOTS-1:0][ROW_W-1:0]   req_row_i,
    input  logic [NUM_SLOTS-1:0][COL_W-1:0]   req_col_i,
    input  logic [NUM_SLOTS-1:0][OBJ_W-1:0]   req_data_i,
    output logic [NUM_SLOTS-1:0]              grant_o,
    output logic [NUM_SLOTS-1:0]              nack_o,
    output logic                              grid_we_o,
    output logic [ROW_W-1:0]                  grid_row_o,
    output logic [COL_W-1:0]                  grid_col_o,
    output logic [OBJ_W-1:0]                  grid_data_o,
    output logic [NUM_SLOTS-1:0]              lock_valid_o
);

    logic                              in_play;
    logic [NUM_SLOTS-1:0]              slot_mask;
    logic [NUM_SLOTS-1:0]              eligible;
    logic [NUM_SLOTS-1:0]              pick_sel;
    logic [1:0]                        pick_idx;
    logic                              pick_valid;

    logic [1:0]                        sel_kind;
    logic [ROW_W-1:0]                  sel_row;
    logic [COL_W-1:0]                  sel_col;
    logic [OBJ_W-1:0]                  sel_data;
    logic                              foreign_locked;
    logic                              own_match;

    logic [1:0]                        ptr_q, ptr_d;
    lock_entry_t [NUM_SLOTS-1:0]       lock_q, lock_d;
    logic [NUM_SLOTS-1:0]              grant_q, grant_d;
    logic [NUM_SLOTS-1:0]              nack_q, nack_d;
    logic                              grid_we_q, grid_we_d;
    logic [ROW_W-1:0]                  grid_row_q, grid_row_d;
    logic [COL_W-1:0]                  grid_col_q, grid_col_d;
    logic [OBJ_W-1:0]                  grid_data_q, grid_data_d;

    always_comb begin
        in_play = (game_state_i == PLAY_STATE);
        unique case (num_players_i)
            2'd0:    slot_mask = 4'b0001;
            2'd1:    slot_mask = 4'b0011;
            2'd2:    slot_mask = 4'b0111;
            default: slot_mask = 4'b1111;
        endcase
        eligible = req_i & slot_mask & {NUM_SLOTS{in_play}};
    end

    rr_pick4 u_rr_pick4 (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .sel_o   (pick_sel),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel_kind       = req_kind_i[pick_idx];
        sel_row        = req_row_i[pick_idx];
        sel_col        = req_col_i[pick_idx];
        sel_data       = req_data_i[pick_idx];
        foreign_locked = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if ((2'(j) != pick_idx) && lock_q[j].valid &&
                (lock_q[j].row == sel_row) && (lock_q[j].col == sel_col)) begin
                foreign_locked = 1'b1;
            end
        end
        own_match = lock_q[pick_idx].valid && (lock_q[pick_idx].row == sel_row) &&
                    (lock_q[pick_idx].col == sel_col);
    end

    always_comb begin
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        grant_d     = '0;
        nack_d      = '0;
        grid_we_d   = 1'b0;
        grid_row_d  = grid_row_q;
        grid_col_d  = grid_col_q;
        grid_data_d = grid_data_q;

        // Locks never survive outside play or on a slot that has been masked off.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!in_play || !slot_mask[i]) begin
                lock_d[i] = '0;
            end
        end

        if (pick_valid) begin
            ptr_d = pick_idx + 2'd1;
            if ((sel_col >= COL_W'(GRID_COLS)) || (sel_kind == KIND_RSVD)) begin
                nack_d = pick_sel;
            end else begin
                unique case (sel_kind)
                    KIND_WRITE: begin
                        if (foreign_locked) begin
                            nack_d = pick_sel;
                        end else begin
                            grant_d     = pick_sel;
                            grid_we_d   = 1'b1;
                            grid_row_d  = sel_row;
                            grid_col_d  = sel_col;
                            grid_data_d = sel_data;
                        end
                    end
                    KIND_LOCK: begin
                        if (foreign_locked) begin
                            nack_d = pick_sel;
                        end else begin
                            grant_d          = pick_sel;
                            lock_d[pick_idx] = '{valid: 1'b1, row: sel_row, col: sel_col};
                        end
                    end
                    KIND_UNLOCK: begin
                        if (own_match) begin
                            grant_d          = pick_sel;
                            lock_d[pick_idx] = '0;
                        end else begin
                            nack_d = pick_sel;
                        end
                    end
                    default: nack_d = pick_sel;
                endcase
            end
        end
    end

    always_ff @(posedge vsync_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q       <= '0;
            lock_q      <= '0;
            grant_q     <= '0;
            nack_q      <= '0;
            grid_we_q   <= 1'b0;
            grid_row_q  <= '0;
            grid_col_q  <= '0;
            grid_data_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            grant_q     <= grant_d;
            nack_q      <= nack_d;
            grid_we_q   <= grid_we_d;
            grid_row_q  <= grid_row_d;
            grid_col_q  <= grid_col_d;
            grid_data_q <= grid_data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            lock_valid_o[i] = lock_q[i].valid;
        end
    end

    assign grant_o     = grant_q;
    assign nack_o      = nack_q;
    assign grid_we_o   = grid_we_q;
    assign grid_row_o  = grid_row_q;
    assign grid_col_o  = grid_col_q;
    assign grid_data_o = grid_data_q;

endmodule

// File: tb/tb_grid_action_arbiter.sv
// Directed self-checking bench for grid_action_arbiter.
module tb_grid_action_arbiter;
    import game_pkg::*;

    logic            vsync;
    logic            reset_n;
    logic [1:0]      num_players;
    logic [2:0]      game_state;
    logic [3:0]      req;
    logic [3:0][1:0] req_kind;
    logic [3:0][2:0] req_row;
    logic [3:0][3:0] req_col;
    logic [3:0][3:0] req_data;
    logic [3:0]      grant;
    logic [3:0]      nack;
    logic            grid_we;
    logic [2:0]      grid_row;
    logic [3:0]      grid_col;
    logic [3:0]      grid_data;
    logic [3:0]      lock_valid;

    int checks = 0;
    int errors = 0;

    grid_action_arbiter dut (
        .vsync_i       (vsync),
        .reset_ni      (reset_n),
        .num_players_i (num_players),
        .game_state_i  (game_state),
        .req_i         (req),
        .req_kind_i    (req_kind),
        .req_row_i     (req_row),
        .req_col_i     (req_col),
        .req_data_i    (req_data),
        .grant_o       (grant),
        .nack_o        (nack),
        .grid_we_o     (grid_we),
        .grid_row_o    (grid_row),
        .grid_col_o    (grid_col),
        .grid_data_o   (grid_data),
        .lock_valid_o  (lock_valid)
    );

    initial vsync = 1'b0;
    always #5 vsync = ~vsync;

    task automatic tick();
        @(posedge vsync);
        #1;
    endtask

    task automatic set_req(input int s, input logic [1:0] k, input logic [2:0] r,
                           input logic [3:0] c, input logic [3:0] d);
        req_kind[s] = k;
        req_row[s]  = r;
        req_col[s]  = c;
        req_data[s] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; num_players = 2'd3; game_state = 3'd2; req = 4'b0001;
        req_kind = '0; req_row = '0; req_col = '0; req_data = '0;
        tick(); tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
        checks++; if (nack !== 4'b0000) begin errors++; $display("FAIL rst_nack: got %b want 0000", nack); end
        checks++; if (grid_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", grid_we); end
        checks++; if ({grid_row, grid_col, grid_data} !== 11'd0) begin errors++; $display("FAIL rst_bus: got %h want 0", {grid_row, grid_col, grid_data}); end
        checks++; if (lock_valid !== 4'b0000) begin errors++; $display("FAIL rst_locks: got %b want 0000", lock_valid); end
        req = 4'b0000; reset_n = 1'b1;
        tick();
        checks++; if (grid_we !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL idle_after_rst: got we=%b grant=%b want 0/0000", grid_we, grant); end
    endtask

    task automatic test_basic_write();
        set_req(0, KIND_WRITE, 3'd7, 4'd2, G_ONION_WHOLE); req = 4'b0001;
        tick();
        req = 4'b0000;
        checks++; if (grant !== 4'b0001 || nack !== 4'b0000) begin errors++; $display("FAIL wr_grant: got g=%b n=%b want 0001/0000", grant, nack); end
        checks++; if (grid_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", grid_we); end
        checks++; if (grid_row !== 3'd7 || grid_col !== 4'd2 || grid_data !== G_ONION_WHOLE) begin errors++; $display("FAIL wr_bus: got %0d,%0d,%0d want 7,2,%0d", grid_row, grid_col, grid_data, G_ONION_WHOLE); end
        tick();
        checks++; if (grant !== 4'b0000 || grid_we !== 1'b0) begin errors++; $display("FAIL wr_pulse: got g=%b we=%b want 0000/0", grant, grid_we); end
        checks++; if (grid_row !== 3'd7 || grid_col !== 4'd2 || grid_data !== G_ONION_WHOLE) begin errors++; $display("FAIL wr_hold: got %0d,%0d,%0d want 7,2,%0d", grid_row, grid_col, grid_data, G_ONION_WHOLE); end
    endtask

    task automatic test_mid_reset();
        set_req(0, KIND_WRITE, 3'd5, 4'd4, G_PLATE); req = 4'b0001;
        tick();
        req = 4'b0000;
        checks++; if (grant !== 4'b0001 || grid_row !== 3'd5) begin errors++; $display("FAIL mr_pre: got g=%b row=%0d want 0001/5", grant, grid_row); end
        reset_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || grid_we !== 1'b0 || grid_row !== 3'd0 || grid_data !== 4'd0) begin errors++; $display("FAIL mr_async: got g=%b we=%b row=%0d data=%0d want all 0", grant, grid_we, grid_row, grid_data); end
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        logic [2:0] exp_r [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        exp_r[0] = 3'd0;    exp_r[1] = 3'd1;    exp_r[2] = 3'd3;    exp_r[3] = 3'd0;
        set_req(0, KIND_WRITE, 3'd0, 4'd0, 4'd1);
        set_req(1, KIND_WRITE, 3'd1, 4'd1, 4'd5);
        set_req(3, KIND_WRITE, 3'd3, 4'd3, 4'd9);
        req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (grant !== exp_g[i] || grid_row !== exp_r[i]) begin errors++; $display("FAIL rr_%0d: got g=%b row=%0d want %b/%0d", i, grant, grid_row, exp_g[i], exp_r[i]); end
        end
        req = 4'b0000;
    endtask

    task automatic test_lock_conflict();
        // pointer is 1 here
        set_req(1, KIND_LOCK, 3'd3, 4'd5, 4'd0); req = 4'b0010;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0010 || lock_valid !== 4'b0010 || grid_we !== 1'b0) begin errors++; $display("FAIL lk_lock: got g=%b lv=%b we=%b want 0010/0010/0", grant, lock_valid, grid_we); end
        set_req(2, KIND_WRITE, 3'd3, 4'd5, G_SOUP); req = 4'b0100;
        tick(); req = 4'b0000;
        checks++; if (nack !== 4'b0100 || grant !== 4'b0000 || grid_we !== 1'b0) begin errors++; $display("FAIL lk_blocked: got n=%b g=%b we=%b want 0100/0000/0", nack, grant, grid_we); end
        set_req(1, KIND_UNLOCK, 3'd3, 4'd5, 4'd0); req = 4'b0010;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0010 || lock_valid !== 4'b0000) begin errors++; $display("FAIL lk_unlock: got g=%b lv=%b want 0010/0000", grant, lock_valid); end
        req = 4'b0100;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0100 || grid_we !== 1'b1 || grid_row !== 3'd3 || grid_col !== 4'd5 || grid_data !== G_SOUP) begin errors++; $display("FAIL lk_retry: got g=%b we=%b %0d,%0d,%0d want 0100/1 3,5,%0d", grant, grid_we, grid_row, grid_col, grid_data, G_SOUP); end
        // pointer is 3: slot0 LOCK wins the race, slot2 then loses against the updated table
        set_req(0, KIND_LOCK, 3'd6, 4'd6, 4'd0);
        set_req(2, KIND_LOCK, 3'd6, 4'd6, 4'd0);
        req = 4'b0101;
        tick(); req = 4'b0100;
        checks++; if (grant !== 4'b0001 || lock_valid !== 4'b0001) begin errors++; $display("FAIL race_first: got g=%b lv=%b want 0001/0001", grant, lock_valid); end
        tick(); req = 4'b0000;
        checks++; if (nack !== 4'b0100 || lock_valid !== 4'b0001) begin errors++; $display("FAIL race_second: got n=%b lv=%b want 0100/0001", nack, lock_valid); end
        set_req(0, KIND_UNLOCK, 3'd1, 4'd1, 4'd0); req = 4'b0001;
        tick(); req = 4'b0000;
        checks++; if (nack !== 4'b0001 || lock_valid !== 4'b0001) begin errors++; $display("FAIL unlock_wrong: got n=%b lv=%b want 0001/0001", nack, lock_valid); end
        set_req(0, KIND_UNLOCK, 3'd6, 4'd6, 4'd0); req = 4'b0001;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0001 || lock_valid !== 4'b0000) begin errors++; $display("FAIL unlock_ok: got g=%b lv=%b want 0001/0000", grant, lock_valid); end
    endtask

    task automatic test_mask_bounds();
        set_req(3, KIND_LOCK, 3'd2, 4'd2, 4'd0); req = 4'b1000;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b1000 || lock_valid !== 4'b1000) begin errors++; $display("FAIL mk_lock3: got g=%b lv=%b want 1000/1000", grant, lock_valid); end
        num_players = 2'd1;
        tick();
        checks++; if (lock_valid !== 4'b0000) begin errors++; $display("FAIL mk_clear: got lv=%b want 0000", lock_valid); end
        set_req(2, KIND_WRITE, 3'd1, 4'd1, 4'd1); req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (grant !== 4'b0000 || nack !== 4'b0000 || grid_we !== 1'b0) begin errors++; $display("FAIL mk_silent_%0d: got g=%b n=%b we=%b want 0", i, grant, nack, grid_we); end
        end
        req = 4'b0000;
        set_req(0, KIND_WRITE, 3'd1, 4'd13, 4'd1); req = 4'b0001;
        tick(); req = 4'b0000;
        checks++; if (nack !== 4'b0001 || grant !== 4'b0000 || grid_we !== 1'b0) begin errors++; $display("FAIL col13: got n=%b g=%b we=%b want 0001/0000/0", nack, grant, grid_we); end
        set_req(0, KIND_RSVD, 3'd1, 4'd1, 4'd1); req = 4'b0001;
        tick(); req = 4'b0000;
        checks++; if (nack !== 4'b0001 || grant !== 4'b0000) begin errors++; $display("FAIL kind3: got n=%b g=%b want 0001/0000", nack, grant); end
        set_req(1, KIND_WRITE, 3'd4, 4'd12, G_ONION_CHOPPED); req = 4'b0010;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0010 || grid_we !== 1'b1 || grid_col !== 4'd12) begin errors++; $display("FAIL col12: got g=%b we=%b col=%0d want 0010/1/12", grant, grid_we, grid_col); end
        num_players = 2'd3;
    endtask

    task automatic test_state_exit();
        set_req(0, KIND_LOCK, 3'd4, 4'd4, 4'd0); req = 4'b0001;
        tick(); req = 4'b0000;
        set_req(3, KIND_LOCK, 3'd4, 4'd5, 4'd0); req = 4'b1000;
        tick(); req = 4'b0000;
        checks++; if (lock_valid !== 4'b1001) begin errors++; $display("FAIL se_locks: got lv=%b want 1001", lock_valid); end
        set_req(0, KIND_WRITE, 3'd4, 4'd4, G_COUNTER); req = 4'b0001;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0001 || grid_we !== 1'b1 || lock_valid !== 4'b1001) begin errors++; $display("FAIL se_ownwrite: got g=%b we=%b lv=%b want 0001/1/1001", grant, grid_we, lock_valid); end
        set_req(3, KIND_WRITE, 3'd4, 4'd4, G_COUNTER); req = 4'b1000;
        tick(); req = 4'b0000;
        checks++; if (nack !== 4'b1000 || grid_we !== 1'b0) begin errors++; $display("FAIL se_foreign: got n=%b we=%b want 1000/0", nack, grid_we); end
        set_req(0, KIND_WRITE, 3'd0, 4'd0, G_PLATE); req = 4'b0001;
        game_state = GS_TITLE;
        tick();
        checks++; if (lock_valid !== 4'b0000 || grant !== 4'b0000 || nack !== 4'b0000) begin errors++; $display("FAIL se_exit: got lv=%b g=%b n=%b want 0000", lock_valid, grant, nack); end
        tick(); tick();
        checks++; if (grant !== 4'b0000 || nack !== 4'b0000 || grid_we !== 1'b0) begin errors++; $display("FAIL se_hold: got g=%b n=%b we=%b want 0", grant, nack, grid_we); end
        game_state = GS_PLAY;
        tick(); req = 4'b0000;
        checks++; if (grant !== 4'b0001 || grid_we !== 1'b1 || grid_data !== G_PLATE) begin errors++; $display("FAIL se_resume: got g=%b we=%b data=%0d want 0001/1/%0d", grant, grid_we, grid_data, G_PLATE); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_mid_reset();
        test_round_robin();
        test_lock_conflict();
        test_mask_bounds();
        test_state_exit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_action_arbiter.md
Name: grid_action_arbiter

Overview:
- Shares the single object_grid write port among up to four player action units.
- Enforces per-cell chop locks so two players cannot work the same counter cell.
- Sits between the per-player action logic and the object_grid register owner.
- Serves one request per vsync cycle using round-robin order.

Parameters:
- NUM_SLOTS, 4, number of requester slots.
- GRID_ROWS, 8, object_grid rows; row index is 3 bits.
- GRID_COLS, 13, object_grid columns; column index is 4 bits, legal values 0..12.
- PLAY_STATE, 3'd2, game_state value in which requests are served.

Ports:
- vsync  input  1  clock; one cycle per video frame.
- reset  input  1  asynchronous, active-low reset.
- num_players  input  2  active slots = num_players+1; slots above that are masked.
- game_state  input  3  current game state.
- req  input  4  per-slot request; the slot holds it until grant or nack.
- req_kind  input  4x2  per-slot op: 0 WRITE, 1 LOCK, 2 UNLOCK, 3 reserved (nacked).
- req_row  input  4x3  target row.
- req_col  input  4x4  target column.
- req_data  input  4x4  object code to write (WRITE only).
- grant  output  4  one-hot; the request was accepted this cycle.
- nack  output  4  one-hot; the request was rejected this cycle.
- grid_we  output  1  object_grid write strobe.
- grid_row  output  3  write row.
- grid_col  output  4  write column.
- grid_data  output  4  write data.
- lock_valid  output  4  per-slot lock-held flag.

Behaviour:
- Reset (reset low, async):
  - grant, nack, grid_we, lock_valid = 0.
  - grid_row, grid_col, grid_data = 0.
  - Round-robin pointer = 0.
  - Lock table cleared.
- All outputs are registered.
- Latency: a request sampled at edge N produces grant/nack and grid_we at edge N (visible in cycle N+1).
- The requester drops req in the cycle after it sees grant or nack.
- At most one of grant/nack is set per cycle; it is a single-cycle pulse.
- Eligible slot: req=1, slot index <= num_players, and game_state==PLAY_STATE.
- Selection: the first eligible slot at or after the pointer, wrapping 3->0.
- After serving slot k (grant or nack), the pointer becomes k+1 mod 4. With no eligible slot, the pointer holds.
- Lock table: one entry per slot {valid, row, col}. A cell is "foreign-locked" for slot k if another slot j!=k holds a valid lock on the same row/col.
- Decision for the selected slot k:
  - req_col>12 or kind==3: nack, no write, no table change.
  - WRITE:
    - Foreign-locked: nack.
    - Otherwise: grant, grid_we=1, grid_row/col/data = request fields.
    - A WRITE does not change k's own lock.
  - LOCK:
    - Foreign-locked: nack.
    - Otherwise: grant; entry k = {1,row,col}, replacing any prior lock held by k.
  - UNLOCK:
    - Entry k valid with matching row/col: grant, clear entry k.
    - Otherwise: nack.
- grid_we is 0 in every cycle without a WRITE grant. grid_row/col/data hold their last values when grid_we=0.
- Leaving PLAY_STATE:
  - In the first cycle game_state!=PLAY_STATE, all locks clear.
  - No grants or nacks are issued while outside PLAY_STATE.
  - The pointer holds.
- Lowering num_players: locks of masked slots clear on the next edge.
- Two slots targeting the same free cell in the same cycle: only the selected slot is served. The other is evaluated in a later cycle against the updated table. For LOCK vs LOCK, the later slot is therefore nacked.
- Reset asserted mid-operation: any pending decision is dropped; outputs return to reset values immediately.

Decomposition:
- Shared package (game_pkg) holds:
  - req_kind encoding (KIND_WRITE/LOCK/UNLOCK).
  - Object codes (e.g. G_ONION_WHOLE).
  - GRID_ROWS/GRID_COLS.
  - PLAY_STATE and other game_state encodings.
- One sub-module, rr_pick4: combinational round-robin picker (req mask + pointer -> one-hot select, valid).

Test Plan:
- Reset: hold reset=0 for 2 cycles -> all outputs 0 and lock_valid=4'b0000. Then release with game_state=2, num_players=3, no req -> grid_we stays 0.
- Basic write: slot0 WRITE row7 col2 data=G_ONION_WHOLE -> next cycle grant=4'b0001, grid_we=1, grid_row=7, grid_col=2, grid_data=G_ONION_WHOLE. One-cycle pulse.
- Round-robin: slots 0,1,3 WRITE held continuously (each re-requests after grant), pointer=0 -> grant sequence 0001, 0010, 1000, 0001.
- Lock conflict:
  - Slot1 LOCK (3,5) -> grant, lock_valid=0010.
  - Slot2 WRITE (3,5) -> nack=0100, grid_we=0.
  - Slot1 UNLOCK (3,5) -> grant, lock_valid=0000.
  - Slot2 WRITE (3,5) retried -> grant, grid_we=1.
- Masking and bounds:
  - num_players=1, slot2 req -> no response ever.
  - Slot0 WRITE col=13 -> nack=0001.
  - Slot0 kind=3 -> nack.
- State exit: slot0 and slot3 hold locks; game_state 2->0 -> lock_valid=0000 the next cycle, and a pending slot0 req gets no grant until game_state returns to 2.
